// File: rtl/sprite_plotter.sv
// Sprite box walker: fetches SPR_W x SPR_H colours from an external 1-cycle ROM and
// emits one registered pixel per clock with clipping, blackout and transparency handling.
module sprite_plotter #(
    parameter int unsigned SPR_W   = 20,
    parameter int unsigned SPR_H   = 16,
    parameter int unsigned NUM_SPR = 4,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned SCR_W   = 320,
    parameter int unsigned SCR_H   = 240,
    parameter logic [2:0]  TRANSP  = 3'b000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [8:0]        x_init,
    input  logic [7:0]        y_init,
    input  logic [1:0]        sprite_sel,
    input  logic              blackout,
    input  logic              skip_transp,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [8:0]        x,
    output logic [7:0]        y,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int unsigned N_PIX = SPR_W * SPR_H;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DRAIN1 = 3'd2;
    localparam logic [2:0] S_DRAIN2 = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    generate
        if ((64'(1) << ADDR_W) < 64'(NUM_SPR) * 64'(N_PIX)) begin : g_bad_addr_w
            $error("sprite_plotter: ADDR_W too small for NUM_SPR sprites");
        end
    endgenerate

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             accept_c;
    logic             last_c;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [8:0]       x_lat;
    logic [7:0]       y_lat;
    logic             blk;
    logic             skp;

    logic             d1_valid;
    logic [COL_W-1:0] d1_col;
    logic [ROW_W-1:0] d1_row;

    logic [ADDR_W-1:0] base_c;
    logic [9:0]        wx_c;
    logic [8:0]        wy_c;
    logic              clip_c;
    logic              transp_c;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = (col == COL_W'(SPR_W - 1)) && (row == ROW_W'(SPR_H - 1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH:  if (last_c) state_nxt = S_DRAIN1;
            S_DRAIN1: state_nxt = S_DRAIN2;
            S_DRAIN2: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Sprite base address wraps modulo 2^ADDR_W for out-of-range selects
    assign base_c   = ADDR_W'(32'(sprite_sel) * 32'(N_PIX));
    assign wx_c     = 10'(x_lat) + 10'(d1_col);
    assign wy_c     = 9'(y_lat) + 9'(d1_row);
    assign clip_c   = (32'(wx_c) >= SCR_W) || (32'(wy_c) >= SCR_H);
    assign transp_c = skp && !blk && (rom_data == TRANSP);

    // Address walk, pipeline stage aligned with the ROM read, and pixel output register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col      <= '0;
            row      <= '0;
            x_lat    <= '0;
            y_lat    <= '0;
            blk      <= 1'b0;
            skp      <= 1'b0;
            d1_valid <= 1'b0;
            d1_col   <= '0;
            d1_row   <= '0;
            rom_addr <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy     <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_DONE);
            d1_valid <= (state == S_FETCH);

            if (accept_c) begin
                x_lat    <= x_init;
                y_lat    <= y_init;
                blk      <= blackout;
                skp      <= skip_transp;
                col      <= '0;
                row      <= '0;
                rom_addr <= base_c;
            end else if (state == S_FETCH) begin
                d1_col <= col;
                d1_row <= row;
                if (!last_c) begin
                    rom_addr <= rom_addr + ADDR_W'(1);
                    if (col == COL_W'(SPR_W - 1)) begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
            end

            if (d1_valid) begin
                x      <= wx_c[8:0];
                y      <= wy_c[7:0];
                colour <= blk ? 3'b000 : rom_data;
                plot   <= !clip_c && !transp_c;
            end else begin
                plot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: a raster-order pixel model predicts every output
// each cycle, and literal expectations pin key pixels, counts and timings per run.
module tb_sprite_plotter;

    localparam int SW   = 20;
    localparam int SH   = 16;
    localparam int AW   = 11;
    localparam int NPIX = SW * SH;
    localparam int SCRW = 320;
    localparam int SCRH = 240;
    localparam int ROMN = 2048;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [8:0]    x_init = '0;
    logic [7:0]    y_init = '0;
    logic [1:0]    sprite_sel = '0;
    logic          blackout = 1'b0;
    logic          skip_transp = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [2:0]    rom_data;
    logic [8:0]    x;
    logic [7:0]    y;
    logic [2:0]    colour;
    logic          plot;
    logic          busy;
    logic          done;

    logic [2:0] rom_mem [0:ROMN-1];

    int total = 0;
    int bad   = 0;

    // model state
    int cyc = 0;
    int acc = 0;
    bit act = 1'b0;
    int m_x = 0, m_y = 0, m_sel = 0;
    bit m_blk = 1'b0, m_skp = 1'b0;
    int ex = 0, ey = 0, ec = 0;

    // per-run observations
    int plot_cnt = 0, done_seen = 0, done_r = 0, f_addr = 0;
    int f_x = 0, f_y = 0, f_c = 0, f_p = 0, l_x = 0, l_y = 0;

    sprite_plotter dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .x_init     (x_init),
        .y_init     (y_init),
        .sprite_sel (sprite_sel),
        .blackout   (blackout),
        .skip_transp(skip_transp),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // external ROM, one cycle read latency
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string name, input int a, input int e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, a, e, $time);
        end
    endtask

    // acceptance model: a start is taken at any edge where the engine is not busy
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (start && !(act && (cyc - acc) <= NPIX + 3)) begin
                act   = 1'b1;
                acc   = cyc;
                m_x   = int'(x_init);
                m_y   = int'(y_init);
                m_sel = int'(sprite_sel);
                m_blk = blackout;
                m_skp = skip_transp;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        int r, k, wx, wy, d, ep, ea;
        bit pix;
        if (!resetn) begin
            chk("rst_plot", int'(plot), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_x", int'(x), 0);
            chk("rst_y", int'(y), 0);
            chk("rst_colour", int'(colour), 0);
            chk("rst_rom_addr", int'(rom_addr), 0);
            ex = 0; ey = 0; ec = 0;
        end else begin
            r   = act ? (cyc - acc + 1) : 0;
            pix = act && r >= 3 && r <= NPIX + 2;
            ep  = 0;
            if (pix) begin
                k  = r - 3;
                wx = m_x + (k % SW);
                wy = m_y + (k / SW);
                d  = int'(rom_mem[(m_sel * NPIX + k) % ROMN]);
                ex = wx % 512;
                ey = wy % 256;
                ec = m_blk ? 0 : d;
                ep = (wx < SCRW && wy < SCRH && !(m_skp && !m_blk && d == 0)) ? 1 : 0;
            end
            chk("busy", int'(busy), (act && r >= 1 && r <= NPIX + 3) ? 1 : 0);
            chk("done", int'(done), (act && r == NPIX + 3) ? 1 : 0);
            chk("plot", int'(plot), ep);
            chk("x", int'(x), ex);
            chk("y", int'(y), ey);
            chk("colour", int'(colour), ec);
            if (act && r >= 1 && r <= NPIX) begin
                ea = (m_sel * NPIX + r - 1) % ROMN;
                chk("rom_addr", int'(rom_addr), ea);
            end
            if (act && r == 1) begin
                plot_cnt = 0; done_seen = 0; done_r = 0;
                f_addr = int'(rom_addr);
            end
            if (plot) plot_cnt++;
            if (done) begin done_seen++; done_r = r; end
            if (act && r == 3) begin
                f_x = int'(x); f_y = int'(y); f_c = int'(colour); f_p = int'(plot);
            end
            if (act && r == NPIX + 2) begin
                l_x = int'(x); l_y = int'(y);
            end
        end
    end

    task automatic fill_const(input logic [2:0] v);
        for (int i = 0; i < ROMN; i++) rom_mem[i] = v;
    endtask

    task automatic fill_pattern(input int seed);
        for (int i = 0; i < ROMN; i++) rom_mem[i] = 3'((i * seed + i / 7) % 8);
    endtask

    // one sprite run; optional stray starts at cycles 10 and N+3, optional reset at abort_at
    task automatic run(input int xi, input int yi, input int sel, input bit blk,
                       input bit skp, input bit extra, input int abort_at);
        @(negedge clk);
        x_init      = 9'(xi);
        y_init      = 8'(yi);
        sprite_sel  = 2'(sel);
        blackout    = blk;
        skip_transp = skp;
        start       = 1'b1;
        for (int i = 1; i <= NPIX + 8; i++) begin
            @(negedge clk);
            start = extra && (i == 10 || i == NPIX + 3);
            if (i == abort_at) begin
                #2 resetn = 1'b0;
                #1;
                chk("abort_plot", int'(plot), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_x", int'(x), 0);
                chk("abort_y", int'(y), 0);
                chk("abort_colour", int'(colour), 0);
                chk("abort_rom_addr", int'(rom_addr), 0);
                @(negedge clk);
                #2 resetn = 1'b1;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        fill_const(3'b101);
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        start = 1'b0;
        #2 resetn = 1'b1;

        // 1: plain sprite, constant colour 5
        run(100, 50, 0, 1'b0, 1'b0, 1'b0, 0);
        chk("t1_plots", plot_cnt, 320);
        chk("t1_first_x", f_x, 100);
        chk("t1_first_y", f_y, 50);
        chk("t1_first_colour", f_c, 5);
        chk("t1_first_plot", f_p, 1);
        chk("t1_last_x", l_x, 119);
        chk("t1_last_y", l_y, 65);
        chk("t1_done_cycle", done_r, 323);
        chk("t1_done_count", done_seen, 1);

        // 2: blackout with transparent words present and skip_transp set
        fill_pattern(3);
        run(40, 60, 1, 1'b1, 1'b1, 1'b0, 0);
        chk("t2_plots", plot_cnt, 320);
        chk("t2_first_colour", f_c, 0);

        // 3: clipped at bottom-right corner
        fill_const(3'b010);
        run(310, 230, 0, 1'b0, 1'b0, 1'b0, 0);
        chk("t3_plots", plot_cnt, 100);
        chk("t3_done_cycle", done_r, 323);

        // 4: sprite 2, first word transparent
        fill_const(3'b111);
        rom_mem[640] = 3'b000;
        run(20, 30, 2, 1'b0, 1'b1, 1'b0, 0);
        chk("t4_first_addr", f_addr, 640);
        chk("t4_plots", plot_cnt, 319);
        chk("t4_first_plot", f_p, 0);
        chk("t4_first_x", f_x, 20);

        // 5: stray starts while busy
        fill_pattern(5);
        run(0, 0, 1, 1'b0, 1'b0, 1'b1, 0);
        chk("t5_done_count", done_seen, 1);
        chk("t5_done_cycle", done_r, 323);
        repeat (10) @(negedge clk);
        chk("t5_no_restart", int'(busy), 0);

        // 6: reset in cycle 100, then a full run
        fill_pattern(7);
        run(200, 100, 3, 1'b0, 1'b0, 1'b0, 100);
        repeat (340) @(negedge clk);
        chk("t6_abort_no_done", done_seen, 0);
        run(200, 100, 3, 1'b0, 1'b0, 1'b0, 0);
        chk("t6_rerun_done_cycle", done_r, 323);
        chk("t6_rerun_first_addr", f_addr, 960);
        chk("t6_rerun_last_x", l_x, 219);
        chk("t6_rerun_last_y", l_y, 115);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Generic sprite rendering engine that sits directly upstream of main_datapath's pixel mux.
- On a start pulse it walks a SPR_W x SPR_H box anchored at (x_init, y_init) and fetches each pixel colour from an external sprite ROM with 1-cycle read latency.
- It emits one registered (x, y, colour, plot) pixel per clock and pulses done when the box is finished.
- It replaces the per-object walkers (user, enemy, bullet) with one parameterised block that also handles blackout, transparency and off-screen clipping.

Parameters:
- SPR_W, 20, sprite width in pixels (>=1)
- SPR_H, 16, sprite height in pixels (>=1)
- NUM_SPR, 4, number of sprites stored back-to-back in ROM
- ADDR_W, 11, ROM address width; must satisfy 2^ADDR_W >= NUM_SPR*SPR_W*SPR_H
- SCR_W, 320, screen width; pixels with x >= SCR_W are clipped
- SCR_H, 240, screen height; pixels with y >= SCR_H are clipped
- TRANSP, 3'b000, colour code treated as transparent

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only while busy=0
- x_init  in  9  top-left x of sprite box, latched at accept
- y_init  in  8  top-left y of sprite box, latched at accept
- sprite_sel  in  2  sprite index (< NUM_SPR), latched at accept
- blackout  in  1  when 1 at accept: paint the whole box colour 0 and ignore ROM
- skip_transp  in  1  when 1 at accept: suppress plot for TRANSP pixels
- rom_addr  out  ADDR_W  sprite ROM read address (registered)
- rom_data  in  3  ROM colour, valid the cycle after rom_addr
- x  out  9  pixel x (registered)
- y  out  8  pixel y (registered)
- colour  out  3  pixel colour (registered)
- plot  out  1  pixel write enable (registered)
- busy  out  1  high from the accept edge until done completes
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, resetn=0): state IDLE, counters 0, and every output 0 (rom_addr, x, y, colour, plot, busy, done). Reset mid-sprite aborts immediately; no done is issued.
- States:
  - IDLE: busy=0. start=1 at an edge latches x_init, y_init, sprite_sel, blackout and skip_transp, clears col/row, and goes to FETCH with busy=1 on the next cycle.
  - FETCH: each cycle rom_addr <= sprite_sel*SPR_W*SPR_H + row*SPR_W + col. col increments and wraps at SPR_W-1 to 0 with row+1. After issuing address N-1 (N = SPR_W*SPR_H), go to DRAIN1.
  - DRAIN1: pipeline stage, lasts one cycle; then DRAIN2.
  - DRAIN2: lasts one cycle; registers the last pixel.
  - DONE: done=1 for exactly one cycle, plot=0; busy falls at the end of this cycle; returns to IDLE.
- Pipeline:
  - (col, row) is delayed 2 stages alongside the ROM read, so pixel k (raster order, k=0..N-1) appears on x/y/colour/plot in cycle k+3, where cycle 1 is the first after the accept edge.
  - done is in cycle N+3; start is first re-acceptable in cycle N+4.
- Pixel value:
  - x = x_init+col and y = y_init+row, both computed 1 bit wider than the port.
  - colour = 0 if blackout, else rom_data.
  - plot = 1 unless the pixel is clipped (wide x >= SCR_W or wide y >= SCR_H), or (skip_transp and !blackout and rom_data == TRANSP).
  - When plot=0, x/y/colour still update; consumers ignore them.
- Blackout always plots every unclipped pixel, including TRANSP ones.
- Outside sprite pixel cycles: plot=0; x, y and colour hold their last values.
- start while busy=1 (including the DONE cycle) is ignored and has no side effect.
- start and resetn deasserting in the same cycle: reset has priority.
- sprite_sel >= NUM_SPR: address computed modulo 2^ADDR_W; no error flag.

Test Plan:
1. Reset, then start with x_init=100, y_init=50, sprite 0, SPR_W=20, SPR_H=16, ROM=all 3'b101 -> 320 plots in cycles 3..322. First pixel (100,50), last (119,65), colour 5. done only in cycle 323; busy high cycles 1..323.
2. Same as 1 with blackout=1 -> 320 plots, all colour 0; rom_data ignored.
3. x_init=310, y_init=230, ROM all 3'b010 -> plot only where x <= 319 and y <= 239: 10x10 = 100 plots. done still in cycle 323.
4. sprite_sel=2, skip_transp=1, ROM word 0 of sprite 2 = 000, rest = 3'b111 -> first rom_addr = 640; 319 plots; pixel (x_init, y_init) not plotted.
5. Extra start pulses in cycles 10 and 323 of a run -> ignored: exactly one done, with no restart.
6. resetn pulsed low in cycle 100 -> all outputs 0 immediately; no done. A subsequent start runs a full, correct 320-pixel sprite.
